regfile: RTL and testbench
==========================

// Module: regfile
// PURPOSE
//   RV32I integer register file: 32 x 32-bit registers, x0 hardwired to zero.
//   Sits in the decode stage of the rv32i core.
//   Provides two combinational read ports (rs1/rs2) and one synchronous write port (rd).
// PARAMETERS
//   XLEN    32  data width of each register
//   ADDR_W  5   register index width (2**ADDR_W registers)
// PORTS
//   clk          in   1       system clock; all state updates on rising edge
//   rst_n        in   1       reset, synchronous, active-low
//   r1_reg_name  in   ADDR_W  read port 1 register index
//   r1_reg_val   out  XLEN    read port 1 data
//   r2_reg_name  in   ADDR_W  read port 2 register index
//   r2_reg_val   out  XLEN    read port 2 data
//   w_enable     in   1       write strobe, sampled on rising clk
//   w_reg_name   in   ADDR_W  write register index
//   w_reg_val    in   XLEN    write data
// BEHAVIOUR
//   Interface: one clock (clk); reset rst_n is synchronous and active-low.
//   Reset:
//     - On rising clk with rst_n=0, all registers x1..x31 clear to 0.
//     - Reset has priority over a simultaneous write.
//     - With reads combinational, both outputs read 0 after the reset edge.
//     - Reset asserted mid-sequence discards all prior writes.
//   Read:
//     - Purely combinational, zero latency:
//       r1_reg_val = (r1_reg_name==0) ? 0 : reg[r1_reg_name]. Port 2 identical.
//     - Both ports are independent. Either may address any register, including
//       the same register as the other port.
//   Write:
//     - On rising clk with rst_n=1 and w_enable=1, reg[w_reg_name] <= w_reg_val.
//     - w_enable=0: no state change.
//     - Writes to x0 are ignored. x0 always reads 0.
//   Read-during-write, same index in the same cycle:
//     - No internal bypass: the read returns the old value before the edge.
//     - The new value appears immediately after the edge, through the
//       combinational path.
//   Power-up (before the first reset): register contents are undefined.
//     - x0 still reads 0.
//   Outputs have no X-propagation for indices 0..31. All indices are valid.
// TESTING
//   1. rst_n=0 for 1 edge, r1=r2=0 -> r1_reg_val=r2_reg_val=0x00000000.
//   2. Write x5=42 on edge 1, x3=53 on edge 2 (w_enable=1), then w_enable=0,
//      r1=5, r2=3 -> r1_reg_val=0x0000002A, r2_reg_val=0x00000035.
//   3. Write x0=0xDEADBEEF, then r1=0 -> r1_reg_val=0.
//   4. w_enable=0, w_reg_name=7, w_reg_val=0x1234, then r1=7 -> reads prior
//      value (0 after reset).
//   5. r1=r2=5 with w_enable=1, w_reg_name=5, w_reg_val=99:
//      -> reads 42 before the edge, 99 after it.
//   6. rst_n=0 together with w_enable=1 (x9=77), then r1=9, r2=5 -> both read 0.

Source files
------------

// File: rtl/regfile.sv
// RV32I integer register file: 32 x XLEN, x0 hardwired to zero.
// Two combinational read ports, one synchronous write port.
module regfile #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] r1_reg_name,
   output logic [XLEN-1:0]   r1_reg_val,
   input  logic [ADDR_W-1:0] r2_reg_name,
   output logic [XLEN-1:0]   r2_reg_val,
   input  logic              w_enable,
   input  logic [ADDR_W-1:0] w_reg_name,
   input  logic [XLEN-1:0]   w_reg_val
);

   localparam int NREG = 2 ** ADDR_W;

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];

   // Entry 0 is held at zero so the array stays uniform; the read mux
   // also forces zero so x0 is clean even before the first reset.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (w_enable && (w_reg_name != '0)) begin
         regs_d[w_reg_name] = w_reg_val;
      end
      regs_d[0] = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   always_comb begin
      r1_reg_val = '0;
      r2_reg_val = '0;
      if (r1_reg_name != '0) begin
         r1_reg_val = regs_q[r1_reg_name];
      end
      if (r2_reg_name != '0) begin
         r2_reg_val = regs_q[r2_reg_name];
      end
   end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed steps, then random traffic
// against an array-based reference model.
module tb_regfile;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  r1_reg_name;
   logic [31:0] r1_reg_val;
   logic [4:0]  r2_reg_name;
   logic [31:0] r2_reg_val;
   logic        w_enable;
   logic [4:0]  w_reg_name;
   logic [31:0] w_reg_val;

   int unsigned passed = 0;
   int unsigned total  = 0;

   logic [31:0] mdl [32];

   regfile #(.XLEN(32), .ADDR_W(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .r1_reg_name (r1_reg_name),
      .r1_reg_val  (r1_reg_val),
      .r2_reg_name (r2_reg_name),
      .r2_reg_val  (r2_reg_val),
      .w_enable    (w_enable),
      .w_reg_name  (w_reg_name),
      .w_reg_val   (w_reg_val)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mdl_rd(input logic [4:0] idx);
      return (idx == 5'd0) ? 32'd0 : mdl[idx];
   endfunction

   function automatic void chk(input string tag,
                               input logic [31:0] obs,
                               input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endfunction

   task automatic step();
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      end else if (w_enable && w_reg_name != 5'd0) begin
         mdl[w_reg_name] = w_reg_val;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_r1"}, r1_reg_val, mdl_rd(r1_reg_name));
      chk({tag, "_r2"}, r2_reg_val, mdl_rd(r2_reg_name));
   endtask

   initial begin
      rst_n       = 1'b0;
      r1_reg_name = 5'd0;
      r2_reg_name = 5'd0;
      w_enable    = 1'b0;
      w_reg_name  = 5'd0;
      w_reg_val   = 32'd0;
      for (int i = 0; i < 32; i++) mdl[i] = 32'hx;
      @(negedge clk);
      chk("pwrup_x0_r1", r1_reg_val, 32'd0);
      chk("pwrup_x0_r2", r2_reg_val, 32'd0);

      // 1: reset
      step();
      chk("rst_r1", r1_reg_val, 32'd0);
      chk("rst_r2", r2_reg_val, 32'd0);
      for (int i = 1; i < 32; i += 6) begin
         r1_reg_name = 5'(i);
         r2_reg_name = 5'(31 - i);
         #1;
         chk_model("rst_sweep");
         chk("rst_sweep_zero", r1_reg_val, 32'd0);
      end
      rst_n = 1'b1;

      // 2: two writes then read back
      w_enable   = 1'b1;
      w_reg_name = 5'd5;
      w_reg_val  = 32'd42;
      step();
      w_reg_name = 5'd3;
      w_reg_val  = 32'd53;
      step();
      w_enable    = 1'b0;
      r1_reg_name = 5'd5;
      r2_reg_name = 5'd3;
      #1;
      chk("wr_x5", r1_reg_val, 32'h0000002A);
      chk("wr_x3", r2_reg_val, 32'h00000035);

      // 3: write to x0 ignored
      w_enable   = 1'b1;
      w_reg_name = 5'd0;
      w_reg_val  = 32'hDEADBEEF;
      step();
      w_enable    = 1'b0;
      r1_reg_name = 5'd0;
      #1;
      chk("x0_write", r1_reg_val, 32'd0);

      // 4: disabled write
      w_enable   = 1'b0;
      w_reg_name = 5'd7;
      w_reg_val  = 32'h1234;
      step();
      r1_reg_name = 5'd7;
      #1;
      chk("wen_off", r1_reg_val, 32'd0);

      // 5: read during write, same index
      r1_reg_name = 5'd5;
      r2_reg_name = 5'd5;
      w_enable    = 1'b1;
      w_reg_name  = 5'd5;
      w_reg_val   = 32'd99;
      #1;
      chk("rdw_pre_r1", r1_reg_val, 32'd42);
      chk("rdw_pre_r2", r2_reg_val, 32'd42);
      step();
      chk("rdw_post_r1", r1_reg_val, 32'd99);
      chk("rdw_post_r2", r2_reg_val, 32'd99);

      // 6: reset beats a simultaneous write
      rst_n      = 1'b0;
      w_enable   = 1'b1;
      w_reg_name = 5'd9;
      w_reg_val  = 32'd77;
      step();
      rst_n       = 1'b1;
      w_enable    = 1'b0;
      r1_reg_name = 5'd9;
      r2_reg_name = 5'd5;
      #1;
      chk("rst_pri_x9", r1_reg_val, 32'd0);
      chk("rst_pri_x5", r2_reg_val, 32'd0);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         rst_n       = ($urandom_range(0, 49) != 0);
         w_enable    = ($urandom_range(0, 3) != 0);
         w_reg_name  = 5'($urandom_range(0, 31));
         w_reg_val   = $urandom;
         r1_reg_name = 5'($urandom_range(0, 31));
         r2_reg_name = ($urandom_range(0, 3) == 0) ? w_reg_name
                                                   : 5'($urandom_range(0, 31));
         #1;
         chk_model("rnd_pre");
         step();
         chk_model("rnd_post");
      end

      rst_n    = 1'b1;
      w_enable = 1'b0;
      for (int i = 0; i < 32; i++) begin
         r1_reg_name = 5'(i);
         r2_reg_name = 5'(31 - i);
         #1;
         chk_model("final_sweep");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
